// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main control: a registered Moore FSM that sequences fetch/decode/
// execute/memory/write-back, waits on memory ready, flags illegal opcodes and counts retirements.
module multicycle_ctrl #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [OP_W-1:0]    instr_op_i,
    input  logic               mem_ready_i,
    output logic               PCWrite_o,
    output logic               PCWriteCond_o,
    output logic               BranchNe_o,
    output logic [1:0]         PCSource_o,
    output logic               IorD_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               IRWrite_o,
    output logic               RegDst_o,
    output logic               RegWrite_o,
    output logic               MemToReg_o,
    output logic               ALUSrcA_o,
    output logic [1:0]         ALUSrcB_o,
    output logic [ALUOP_W-1:0] ALU_op_o,
    output logic [3:0]         state_o,
    output logic               illegal_o,
    output logic [CNT_W-1:0]   instr_cnt_o
);

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_MADR = 4'd2,
        S_MRD  = 4'd3,
        S_MWB  = 4'd4,
        S_MWR  = 4'd5,
        S_REX  = 4'd6,
        S_RWB  = 4'd7,
        S_IEX  = 4'd8,
        S_IWB  = 4'd9,
        S_BR   = 4'd10,
        S_JMP  = 4'd11,
        S_ILL  = 4'd12
    } state_t;

    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'b001010);
    localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] OP_LUI  = OP_W'(6'b001111);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_ADDI  = 3'b100;
    localparam logic [2:0] ALU_SLTI  = 3'b101;
    localparam logic [2:0] ALU_LUI   = 3'b110;
    localparam logic [2:0] ALU_ORI   = 3'b111;

    state_t           state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IF;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, opcode capture and retirement counting.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        retire  = 1'b0;
        case (state_q)
            S_IF: begin
                if (mem_ready_i) state_d = S_ID;
            end
            S_ID: begin
                op_d = instr_op_i;
                case (instr_op_i)
                    OP_R:                               state_d = S_REX;
                    OP_LW, OP_SW:                       state_d = S_MADR;
                    OP_ADDI, OP_SLTI, OP_ORI, OP_LUI:   state_d = S_IEX;
                    OP_BEQ, OP_BNE:                     state_d = S_BR;
                    OP_J:                               state_d = S_JMP;
                    default:                            state_d = S_ILL;
                endcase
            end
            S_MADR: begin
                state_d = (op_q == OP_LW) ? S_MRD : S_MWR;
            end
            S_MRD: begin
                if (mem_ready_i) state_d = S_MWB;
            end
            S_MWR: begin
                if (mem_ready_i) begin
                    state_d = S_IF;
                    retire  = 1'b1;
                end
            end
            S_REX: state_d = S_RWB;
            S_IEX: state_d = S_IWB;
            S_MWB, S_RWB, S_IWB, S_BR, S_JMP: begin
                state_d = S_IF;
                retire  = 1'b1;
            end
            // Illegal opcodes return to fetch without retiring; PC already advanced.
            S_ILL:   state_d = S_IF;
            default: state_d = S_IF;
        endcase
        cnt_d = retire ? cnt_q + 1'b1 : cnt_q;
    end

    logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
    logic       ir_write, reg_dst, reg_write, mem_to_reg, alu_src_a, illegal;
    logic [1:0] pc_source, alu_src_b;
    logic [2:0] alu_op;

    // Moore decode: state, captured opcode and mem_ready_i only.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_source     = 2'b00;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = ALU_ADD;
        illegal       = 1'b0;
        case (state_q)
            S_IF: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready_i;
                pc_write  = mem_ready_i;
            end
            S_ID: begin
                alu_src_b = 2'b11;
            end
            S_MADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALU_ADDI;
            end
            S_MRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_REX: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_RTYPE;
            end
            S_RWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_IEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (op_q)
                    OP_SLTI: alu_op = ALU_SLTI;
                    OP_ORI:  alu_op = ALU_ORI;
                    OP_LUI:  alu_op = ALU_LUI;
                    default: alu_op = ALU_ADDI;
                endcase
            end
            S_IWB: begin
                reg_write = 1'b1;
            end
            S_BR: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                branch_ne     = (op_q == OP_BNE);
            end
            S_JMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_ILL: begin
                illegal = 1'b1;
            end
            default: ;
        endcase
    end

    // While reset is held every control output is forced low, even though IF is the reset state.
    assign PCWrite_o     = rst_i & pc_write;
    assign PCWriteCond_o = rst_i & pc_write_cond;
    assign BranchNe_o    = rst_i & branch_ne;
    assign PCSource_o    = rst_i ? pc_source : 2'b00;
    assign IorD_o        = rst_i & iord;
    assign MemRead_o     = rst_i & mem_read;
    assign MemWrite_o    = rst_i & mem_write;
    assign IRWrite_o     = rst_i & ir_write;
    assign RegDst_o      = rst_i & reg_dst;
    assign RegWrite_o    = rst_i & reg_write;
    assign MemToReg_o    = rst_i & mem_to_reg;
    assign ALUSrcA_o     = rst_i & alu_src_a;
    assign ALUSrcB_o     = rst_i ? alu_src_b : 2'b00;
    assign ALU_op_o      = rst_i ? ALUOP_W'(alu_op) : '0;
    assign illegal_o     = rst_i & illegal;
    assign state_o       = state_q;
    assign instr_cnt_o   = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed and random instructions checked cycle by cycle against
// a path/table reference model; a second instance with a 2-bit counter exercises wrap-around.
module tb_multicycle_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [5:0]  instr_op_i = '0;
    logic        mem_ready_i = 1'b0;
    logic        PCWrite_o, PCWriteCond_o, BranchNe_o, IorD_o, MemRead_o, MemWrite_o;
    logic        IRWrite_o, RegDst_o, RegWrite_o, MemToReg_o, ALUSrcA_o, illegal_o;
    logic [1:0]  PCSource_o, ALUSrcB_o;
    logic [2:0]  ALU_op_o;
    logic [3:0]  state_o;
    logic [31:0] instr_cnt_o;

    logic        w_pcw, w_pcwc, w_bne, w_iord, w_mr, w_mw, w_irw, w_rd, w_rw, w_m2r, w_sa, w_ill;
    logic [1:0]  w_pcs, w_sb;
    logic [2:0]  w_aluop;
    logic [3:0]  w_state;
    logic [1:0]  w_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_cnt = 0;

    always #5 clk_i = ~clk_i;

    multicycle_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
        .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .BranchNe_o(BranchNe_o),
        .PCSource_o(PCSource_o), .IorD_o(IorD_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
        .IRWrite_o(IRWrite_o), .RegDst_o(RegDst_o), .RegWrite_o(RegWrite_o),
        .MemToReg_o(MemToReg_o), .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o),
        .ALU_op_o(ALU_op_o), .state_o(state_o), .illegal_o(illegal_o), .instr_cnt_o(instr_cnt_o)
    );

    multicycle_ctrl #(.CNT_W(2)) dut_w (
        .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
        .PCWrite_o(w_pcw), .PCWriteCond_o(w_pcwc), .BranchNe_o(w_bne),
        .PCSource_o(w_pcs), .IorD_o(w_iord), .MemRead_o(w_mr), .MemWrite_o(w_mw),
        .IRWrite_o(w_irw), .RegDst_o(w_rd), .RegWrite_o(w_rw),
        .MemToReg_o(w_m2r), .ALUSrcA_o(w_sa), .ALUSrcB_o(w_sb),
        .ALU_op_o(w_aluop), .state_o(w_state), .illegal_o(w_ill), .instr_cnt_o(w_cnt)
    );

    // Packed view: {PCWrite,PCWriteCond,BranchNe,PCSource,IorD,MemRead,MemWrite,IRWrite,
    //               RegDst,RegWrite,MemToReg,ALUSrcA,ALUSrcB,ALU_op,illegal}
    function automatic logic [18:0] dut_ctrl();
        return {PCWrite_o, PCWriteCond_o, BranchNe_o, PCSource_o, IorD_o, MemRead_o, MemWrite_o,
                IRWrite_o, RegDst_o, RegWrite_o, MemToReg_o, ALUSrcA_o, ALUSrcB_o, ALU_op_o,
                illegal_o};
    endfunction

    // Reference control table, written from the per-state output list.
    function automatic logic [18:0] ref_ctrl(input int st, input logic [5:0] op, input logic rdy);
        logic pcw = 0, pcwc = 0, bne = 0, iord = 0, mr = 0, mw = 0, irw = 0;
        logic rd = 0, rw = 0, m2r = 0, sa = 0, ill = 0;
        logic [1:0] pcs = 0, sb = 0;
        logic [2:0] aop = 0;
        case (st)
            0:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; aop = 3'b100; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin sa = 1; aop = 3'b010; end
            7:  begin rd = 1; rw = 1; end
            8:  begin
                    sa = 1; sb = 2'b10;
                    aop = (op == 6'b001000) ? 3'b100 : (op == 6'b001010) ? 3'b101 :
                          (op == 6'b001101) ? 3'b111 : 3'b110;
                end
            9:  rw = 1;
            10: begin sa = 1; aop = 3'b001; pcwc = 1; pcs = 2'b01; bne = (op == 6'b000101); end
            11: begin pcw = 1; pcs = 2'b10; end
            12: ill = 1;
            default: ;
        endcase
        return {pcw, pcwc, bne, pcs, iord, mr, mw, irw, rd, rw, m2r, sa, sb, aop, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle starting just after a falling edge: drive, settle, compare, advance.
    task automatic do_cycle(input int st, input logic rdy, input logic [5:0] drive_op,
                            input logic [5:0] cap_op);
        mem_ready_i = rdy;
        instr_op_i  = drive_op;
        #1;
        check($sformatf("state(exp %0d)", st), 32'(state_o), 32'(st));
        check($sformatf("ctrl(st %0d rdy %0b op %b)", st, rdy, cap_op),
              32'(dut_ctrl()), 32'(ref_ctrl(st, cap_op, rdy)));
        check("instr_cnt", instr_cnt_o, exp_cnt);
        check("instr_cnt_w2", 32'(w_cnt), 32'(exp_cnt[1:0]));
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // The state path an opcode walks, from the opcode-class rules.
    function automatic void build_path(input logic [5:0] op, output int p[$], output bit retires);
        retires = 1;
        case (op)
            6'b000000:                                p = '{0, 1, 6, 7};
            6'b100011:                                p = '{0, 1, 2, 3, 4};
            6'b101011:                                p = '{0, 1, 2, 5};
            6'b001000, 6'b001010, 6'b001101, 6'b001111: p = '{0, 1, 8, 9};
            6'b000100, 6'b000101:                     p = '{0, 1, 10};
            6'b000010:                                p = '{0, 1, 11};
            default: begin p = '{0, 1, 12}; retires = 0; end
        endcase
    endfunction

    // wait_if / wait_mem < 0 selects a random number of not-ready cycles.
    task automatic run_instr(input logic [5:0] op, input int wait_if, input int wait_mem);
        int p[$];
        bit retires;
        int w;
        build_path(op, p, retires);
        foreach (p[i]) begin
            if (p[i] == 0 || p[i] == 3 || p[i] == 5) begin
                w = (p[i] == 0) ? wait_if : wait_mem;
                if (w < 0) w = $urandom_range(0, 2);
                for (int k = 0; k < w; k++) do_cycle(p[i], 1'b0, 6'($urandom), op);
                do_cycle(p[i], 1'b1, (p[i] == 1) ? op : 6'($urandom), op);
            end else begin
                do_cycle(p[i], 1'($urandom), (p[i] == 1) ? op : 6'($urandom), op);
            end
        end
        if (retires) exp_cnt++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ctrl"}, 32'(dut_ctrl()), 32'(0));
        check({tag, " state"}, 32'(state_o), 32'(0));
        check({tag, " cnt"}, instr_cnt_o, 32'(0));
        check({tag, " cnt_w2"}, 32'(w_cnt), 32'(0));
    endtask

    logic [5:0] legal_ops [10] = '{6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b001010,
                                  6'b001101, 6'b001111, 6'b100011, 6'b101011, 6'b000010};

    initial begin
        // Reset held: all control outputs low even though the FSM sits in IF.
        rst_i = 1'b0;
        mem_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        check_reset_outputs("in_reset");
        @(negedge clk_i);
        rst_i = 1'b1;
        exp_cnt = 0;

        // Directed steps.
        run_instr(6'b000000, 0, 0);   // R: 0,1,6,7
        check("cnt after R", instr_cnt_o, 32'd1);
        run_instr(6'b100011, 0, 2);   // lw with 2 wait cycles in MRD
        run_instr(6'b000101, 0, 0);   // bne
        run_instr(6'b000100, 1, 0);   // beq with a fetch wait
        run_instr(6'b001101, 0, 0);   // ori; op input randomised during IEX
        run_instr(6'b111111, 0, 0);   // illegal, no retirement
        run_instr(6'b101011, 2, 3);   // sw with waits
        run_instr(6'b000010, 0, 0);   // j
        run_instr(6'b001111, 0, 0);   // lui
        run_instr(6'b001010, 0, 0);   // slti
        run_instr(6'b001000, 0, 0);   // addi

        // Random mix of legal and arbitrary opcodes with random memory waits.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) run_instr(6'($urandom), -1, -1);
            else run_instr(legal_ops[$urandom_range(0, 9)], -1, -1);
        end

        // Reset asserted mid-store: MemWrite must drop immediately.
        do_cycle(0, 1'b1, 6'($urandom), 6'b101011);
        do_cycle(1, 1'b1, 6'b101011, 6'b101011);
        do_cycle(2, 1'b1, 6'($urandom), 6'b101011);
        mem_ready_i = 1'b0;
        #1;
        check("MemWrite in MWR", 32'(MemWrite_o), 32'(1));
        rst_i = 1'b0;
        #1;
        check_reset_outputs("mid_MWR_reset");
        @(negedge clk_i);
        rst_i = 1'b1;
        exp_cnt = 0;

        // Four retirements wrap the 2-bit counter back to zero.
        run_instr(6'b000010, 0, 0);
        run_instr(6'b000100, 0, 0);
        run_instr(6'b000000, 0, 0);
        run_instr(6'b001000, 0, 0);
        #1;
        check("wrap cnt_w2", 32'(w_cnt), 32'(0));
        check("wrap cnt", instr_cnt_o, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete, observed running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multi-cycle main control unit for the MIPS datapath. It replaces the single-cycle opcode decoder with a registered Moore state machine. The FSM sequences fetch, decode, execute, memory and write-back over several cycles, waits on a memory-ready handshake, flags illegal opcodes, and counts retired instructions. It sits between the instruction register opcode field and the multi-cycle datapath muxes, register file, ALU control and data/instruction memory.

## Interface
- OP_W, 6, opcode width
- ALUOP_W, 3, width of ALU_op_o (≥3; encodings below zero-extended)
- CNT_W, 32, width of retired-instruction counter
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- instr_op_i  in  OP_W  opcode from instruction register (valid from ID state on)
- mem_ready_i  in  1  memory completes current access this cycle
- PCWrite_o  out  1  unconditional PC write
- PCWriteCond_o  out  1  conditional PC write (branch)
- BranchNe_o  out  1  1 = branch on not-zero (bne), 0 = on zero (beq)
- PCSource_o  out  2  00 ALU result, 01 ALUOut register, 10 jump target
- IorD_o  out  1  0 = PC addresses memory, 1 = ALUOut
- MemRead_o / MemWrite_o  out  1  memory strobes
- IRWrite_o  out  1  load instruction register
- RegDst_o  out  1  1 = rd, 0 = rt
- RegWrite_o  out  1  register file write
- MemToReg_o  out  1  1 = memory data register, 0 = ALUOut
- ALUSrcA_o  out  1  0 = PC, 1 = rs
- ALUSrcB_o  out  2  00 rt, 01 constant 4, 10 sign/zero-ext imm, 11 imm<<2
- ALU_op_o  out  ALUOP_W  to ALU control
- state_o  out  4  current state (debug)
- illegal_o  out  1  one-cycle pulse, unsupported opcode
- instr_cnt_o  out  CNT_W  retired instructions

## Operation
- Opcodes: R 000000, beq 000100, bne 000101, addi 001000, slti 001010, ori 001101, lui 001111, lw 100011, sw 101011, j 000010.
- ALU_op: 000 add (PC/addr), 010 R-type, 001 subtract (branch), 100 add (addi/lw/sw), 101 slti, 110 lui, 111 ori.
- States (state_o): IF 0, ID 1, MADR 2, MRD 3, MWB 4, MWR 5, REX 6, RWB 7, IEX 8, IWB 9, BR 10, JMP 11, ILL 12.
- IF: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_op=000, PCSource=00, IRWrite=PCWrite=mem_ready_i. Stay until mem_ready_i, then ID.
- ID: ALUSrcA=0, ALUSrcB=11, ALU_op=000. Capture instr_op_i into op_q. Next: R→REX; lw/sw→MADR; addi/slti/ori/lui→IEX; beq/bne→BR; j→JMP; other→ILL.
- MADR: ALUSrcA=1, ALUSrcB=10, ALU_op=100. Next: lw→MRD, sw→MWR.
- MRD: MemRead=1, IorD=1. Hold until mem_ready_i, then MWB.
- MWB: RegWrite=1, MemToReg=1, RegDst=0. Next: IF.
- MWR: MemWrite=1, IorD=1. Hold until mem_ready_i, then IF.
- REX: ALUSrcA=1, ALUSrcB=00, ALU_op=010. Next: RWB.
- RWB: RegDst=1, RegWrite=1, MemToReg=0. Next: IF.
- IEX: ALUSrcA=1, ALUSrcB=10, ALU_op from op_q. Next: IWB.
- IWB: RegDst=0, RegWrite=1, MemToReg=0. Next: IF.
- BR: ALUSrcA=1, ALUSrcB=00, ALU_op=001, PCWriteCond=1, PCSource=01, BranchNe=(op_q==bne). Next: IF.
- JMP: PCWrite=1, PCSource=10. Next: IF.
- ILL: illegal_o=1, no writes. The instruction is treated as a NOP because PC was already advanced in IF. Next: IF.
- Signals not listed for a state are 0. Outputs decode from state, op_q and mem_ready_i only.
- instr_cnt_o increments by 1 on each transition from MWB, MWR (when ready), RWB, IWB, BR or JMP to IF. It does not increment from ILL and wraps modulo 2^CNT_W.

## Timing
- Reset (rst_i=0, async): state=IF, op_q=0, instr_cnt_o=0. All control outputs are forced to 0, including MemRead_o, while reset is held. state_o=0.
- Reset mid-instruction aborts immediately with no further writes. Fetch restarts in the first cycle after release.
- Latency with mem_ready_i held high: lw 5 cycles; R, I-ALU, sw 4; beq, bne, j 3; illegal 3.
- Each low cycle of mem_ready_i in IF/MRD/MWR adds one cycle. All strobes stay stable while waiting.
- PCWrite_o and IRWrite_o in IF are asserted only in the ready cycle. They must never pulse during a wait.
- Changes on instr_op_i outside ID have no effect.

## Test plan
- Reset then mem_ready_i=1, opcode 000000 → states 0,1,6,7,0. RWB asserts RegDst=1 and RegWrite=1. ALU_op=010 in REX. instr_cnt_o=1.
- lw (100011) with mem_ready_i low for 2 cycles in MRD → states 0,1,2,3,3,3,4,0. MemRead/IorD are stable in MRD. MWB asserts MemToReg=1.
- bne (000101) → BR asserts PCWriteCond=1, BranchNe=1, PCSource=01, ALU_op=001. Returns to IF after 3 cycles.
- ori (001101) → IEX ALU_op=111 and ALUSrcB=10; IWB asserts RegWrite=1, RegDst=0. Changing instr_op_i during IEX does not alter ALU_op.
- Opcode 111111 → ILL for one cycle with illegal_o=1 and no RegWrite/MemWrite. instr_cnt_o is unchanged.
- Assert rst_i=0 during MWR with MemWrite=1 → MemWrite drops the same cycle. After release: state 0, instr_cnt_o=0. With CNT_W=2, 4 retirements wrap the counter to 0.
